// File: rtl/bus_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bus_pkg
//  Purpose  : Shared types, default widths and helpers for the serial-bus slave.
//  Revision : 1.0  initial release
// ============================================================================
package bus_pkg;

    localparam int ADDR_LEN_DEF  = 12;
    localparam int DATA_LEN_DEF  = 8;
    localparam int BURST_LEN_DEF = 12;
    localparam int MEM_DEPTH_DEF = 4096;
    localparam int DELAY_W       = 6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_DELAY   = 3'd2,
        ST_WDATA   = 3'd3,
        ST_WCOMMIT = 3'd4,
        ST_RFETCH  = 3'd5,
        ST_RLOAD   = 3'd6,
        ST_RSHIFT  = 3'd7
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_slave_port_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bram_slave_port_if
//  Purpose  : Bit-serial interconnect signals between a bus master and a slave.
//  Revision : 1.0  initial release
// ============================================================================
interface bram_slave_port_if;
    import bus_pkg::*;

    logic [DELAY_W-1:0] s_slave_delay;
    logic               s_read_en;
    logic               s_write_en;
    logic               s_master_valid;
    logic               s_master_ready;
    logic               s_rx_address;
    logic               s_rx_burst;
    logic               s_rx_data;
    logic               s_slave_ready;
    logic               s_slave_valid;
    logic               s_tx_data;
    logic               s_split_en;

    modport slave (
        input  s_slave_delay, s_read_en, s_write_en, s_master_valid, s_master_ready,
        input  s_rx_address, s_rx_burst, s_rx_data,
        output s_slave_ready, s_slave_valid, s_tx_data, s_split_en
    );

    modport master (
        output s_slave_delay, s_read_en, s_write_en, s_master_valid, s_master_ready,
        output s_rx_address, s_rx_burst, s_rx_data,
        input  s_slave_ready, s_slave_valid, s_tx_data, s_split_en
    );

endinterface
`default_nettype wire

// File: rtl/bram_4k.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bram_4k
//  Purpose  : Single-port synchronous RAM, one-cycle read latency, no reset.
//  Revision : 1.0  initial release
// ============================================================================
module bram_4k
    import bus_pkg::*;
#(
    parameter int DEPTH = MEM_DEPTH_DEF,
    parameter int WIDTH = DATA_LEN_DEF
) (
    input  wire                      clk,
    input  wire                      i_we,
    input  wire  [clog2(DEPTH)-1:0]  i_addr,
    input  wire  [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule
`default_nettype wire

// File: rtl/bram_slave_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bram_slave_port
//  Purpose  : Bit-serial bus slave front end for a 4Kx8 block RAM with bursts.
//  Revision : 1.0  initial release
// ============================================================================
module bram_slave_port
    import bus_pkg::*;
#(
    parameter int ADDR_LEN  = ADDR_LEN_DEF,
    parameter int DATA_LEN  = DATA_LEN_DEF,
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  wire              clk,
    input  wire              rst,
    bram_slave_port_if.slave bus
);

    localparam int c_AW    = clog2(MEM_DEPTH);
    localparam int c_CNT_W = clog2((ADDR_LEN > DATA_LEN) ? ADDR_LEN : DATA_LEN) + 1;

    state_t                r_state;
    state_t                w_state_nxt;
    state_t                w_data_state;
    logic [ADDR_LEN-1:0]   r_addr;
    logic [ADDR_LEN-1:0]   w_addr_inc;
    logic [BURST_LEN-1:0]  r_beats;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [DELAY_W-1:0]    r_delay;
    logic                  r_is_read;
    logic [DATA_LEN-1:0]   r_wshift;
    logic [DATA_LEN-1:0]   r_tx_shift;
    logic [DATA_LEN-1:0]   w_ram_rdata;
    logic                  w_ram_we;
    logic                  w_start;
    logic                  w_addr_bit;
    logic                  w_addr_done;
    logic                  w_delay_done;
    logic                  w_wbit;
    logic                  w_wbyte_done;
    logic                  w_rbit;
    logic                  w_rbyte_done;
    logic                  w_last_beat;

    assign w_start      = (r_state == ST_IDLE) & bus.s_master_valid & (bus.s_read_en ^ bus.s_write_en);
    assign w_addr_bit   = w_start | ((r_state == ST_ADDR) & bus.s_master_valid);
    assign w_addr_done  = (r_state == ST_ADDR) & bus.s_master_valid & (r_bit_cnt == c_CNT_W'(ADDR_LEN - 1));
    assign w_delay_done = (r_state == ST_DELAY) & (r_delay == DELAY_W'(1));
    assign w_wbit       = (r_state == ST_WDATA) & bus.s_master_valid;
    assign w_wbyte_done = w_wbit & (r_bit_cnt == c_CNT_W'(DATA_LEN - 1));
    assign w_rbit       = (r_state == ST_RSHIFT) & bus.s_master_ready;
    assign w_rbyte_done = w_rbit & (r_bit_cnt == c_CNT_W'(DATA_LEN - 1));
    // A burst count of 0 still moves one beat, so 0 and 1 both mean "last".
    assign w_last_beat  = (r_beats <= BURST_LEN'(1));
    assign w_addr_inc   = (r_addr == ADDR_LEN'(MEM_DEPTH - 1)) ? '0 : r_addr + ADDR_LEN'(1);
    assign w_data_state = r_is_read ? ST_RFETCH : ST_WDATA;
    assign w_ram_we     = (r_state == ST_WCOMMIT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_start) w_state_nxt = ST_ADDR;
            ST_ADDR:    if (w_addr_done) w_state_nxt = (bus.s_slave_delay != '0) ? ST_DELAY : w_data_state;
            ST_DELAY:   if (w_delay_done) w_state_nxt = w_data_state;
            ST_WDATA:   if (w_wbyte_done) w_state_nxt = ST_WCOMMIT;
            ST_WCOMMIT: w_state_nxt = w_last_beat ? ST_IDLE : ST_WDATA;
            ST_RFETCH:  w_state_nxt = ST_RLOAD;
            ST_RLOAD:   w_state_nxt = ST_RSHIFT;
            ST_RSHIFT:  if (w_rbyte_done) w_state_nxt = w_last_beat ? ST_IDLE : ST_RFETCH;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // Address/burst arrive LSB first; burst stops shifting once its width is filled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr     <= '0;
            r_beats    <= '0;
            r_bit_cnt  <= '0;
            r_delay    <= '0;
            r_is_read  <= 1'b0;
            r_wshift   <= '0;
            r_tx_shift <= '0;
        end else begin
            if (w_start) begin
                r_is_read <= bus.s_read_en;
            end
            if (w_addr_bit) begin
                r_addr <= {bus.s_rx_address, r_addr[ADDR_LEN-1:1]};
                if (r_bit_cnt < c_CNT_W'(BURST_LEN)) begin
                    r_beats <= {bus.s_rx_burst, r_beats[BURST_LEN-1:1]};
                end
                r_bit_cnt <= w_addr_done ? '0 : r_bit_cnt + c_CNT_W'(1);
            end
            if (w_addr_done) begin
                r_delay <= bus.s_slave_delay;
            end
            if (r_state == ST_DELAY) begin
                r_delay <= r_delay - DELAY_W'(1);
            end
            if (w_wbit) begin
                r_wshift  <= {bus.s_rx_data, r_wshift[DATA_LEN-1:1]};
                r_bit_cnt <= w_wbyte_done ? '0 : r_bit_cnt + c_CNT_W'(1);
            end
            if (w_ram_we || w_rbyte_done) begin
                r_addr  <= w_addr_inc;
                r_beats <= r_beats - BURST_LEN'(1);
            end
            if (r_state == ST_RLOAD) begin
                r_tx_shift <= w_ram_rdata;
            end
            if (w_rbit) begin
                r_tx_shift <= {1'b0, r_tx_shift[DATA_LEN-1:1]};
                r_bit_cnt  <= w_rbyte_done ? '0 : r_bit_cnt + c_CNT_W'(1);
            end
        end
    end

    bram_4k #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (DATA_LEN)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (r_addr[c_AW-1:0]),
        .i_wdata (r_wshift),
        .o_rdata (w_ram_rdata)
    );

    assign bus.s_slave_ready = (r_state == ST_IDLE) || (r_state == ST_ADDR) || (r_state == ST_WDATA);
    assign bus.s_slave_valid = (r_state == ST_RSHIFT);
    assign bus.s_tx_data     = r_tx_shift[0];
    assign bus.s_split_en    = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_bram_slave_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bram_slave_port
//  Purpose  : Randomised self-checking bench for bram_slave_port vs a byte-array model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_bram_slave_port;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] model [4096];
    logic [7:0] wbuf  [16];

    bram_slave_port_if bus ();

    bram_slave_port dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_bus();
        bus.s_master_valid = 1'b0;
        bus.s_master_ready = 1'b0;
        bus.s_read_en      = 1'b0;
        bus.s_write_en     = 1'b0;
        bus.s_rx_address   = 1'b0;
        bus.s_rx_burst     = 1'b0;
        bus.s_rx_data      = 1'b0;
    endtask

    // stall_pct < 0 selects the fixed 2-cycle stall at address bit 6.
    task automatic send_addr(input logic [11:0] a, input logic [11:0] bu, input bit is_rd, input int stall_pct);
        int ns;
        bus.s_read_en  = is_rd;
        bus.s_write_en = ~is_rd;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) ns = 0;
            else if (stall_pct < 0) ns = (i == 6) ? 2 : 0;
            else ns = ($urandom_range(99) < stall_pct) ? int'($urandom_range(1, 2)) : 0;
            if (ns > 0) begin
                bus.s_master_valid = 1'b0;
                bus.s_rx_address   = 1'($urandom_range(1));
                bus.s_rx_burst     = 1'($urandom_range(1));
                repeat (ns) @(negedge clk);
            end
            bus.s_master_valid = 1'b1;
            bus.s_rx_address   = a[i];
            bus.s_rx_burst     = bu[i];
            @(negedge clk);
            bus.s_read_en  = 1'($urandom_range(1));
            bus.s_write_en = 1'($urandom_range(1));
        end
        bus.s_master_valid = 1'b0;
    endtask

    task automatic count_low(input bit use_valid, input int exp, input string tag);
        int n = 0;
        while (((use_valid ? bus.s_slave_valid : bus.s_slave_ready) == 1'b0) && n < 200) begin
            n++;
            @(negedge clk);
        end
        check(tag, n, exp);
    endtask

    task automatic write_burst(input logic [11:0] a, input logic [11:0] bu, input int d,
                               input int stall_pct, input int abort_beat, input int abort_bit);
        int beats = (bu == 0) ? 1 : int'(bu);
        bus.s_slave_delay = 6'(d);
        check("wr_idle_rdy", bus.s_slave_ready, 1);
        send_addr(a, bu, 1'b0, stall_pct);
        count_low(1'b0, d, "wr_delay_len");
        for (int k = 0; k < beats; k++) begin
            for (int b = 0; b < 8; b++) begin
                if (k == abort_beat && b == abort_bit) begin
                    rst = 1'b0;
                    #1;
                    check("rst_ready", bus.s_slave_ready, 1);
                    check("rst_valid", bus.s_slave_valid, 0);
                    check("rst_tx", bus.s_tx_data, 0);
                    check("rst_split", bus.s_split_en, 0);
                    check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
                    @(negedge clk);
                    rst = 1'b1;
                    idle_bus();
                    return;
                end
                if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                    bus.s_master_valid = 1'b0;
                    bus.s_rx_data      = 1'($urandom_range(1));
                    @(negedge clk);
                    check("wr_stall_rdy", bus.s_slave_ready, 1);
                end
                bus.s_master_valid = 1'b1;
                bus.s_rx_data      = wbuf[k][b];
                @(negedge clk);
            end
            check("wr_commit_rdy", bus.s_slave_ready, 0);
            bus.s_master_valid = 1'b0;
            model[(int'(a) + k) % 4096] = wbuf[k];
            @(negedge clk);
        end
        check("wr_end_rdy", bus.s_slave_ready, 1);
        idle_bus();
    endtask

    // stall_pct < 0 selects a fixed 3-cycle master_ready drop after bit 4.
    task automatic read_burst(input logic [11:0] a, input logic [11:0] bu, input int d, input int stall_pct);
        int beats = (bu == 0) ? 1 : int'(bu);
        logic [7:0] got;
        logic bit_now;
        int nb;
        int guard;
        bit held;
        bus.s_slave_delay = 6'(d);
        check("rd_idle_rdy", bus.s_slave_ready, 1);
        send_addr(a, bu, 1'b1, stall_pct);
        for (int k = 0; k < beats; k++) begin
            count_low(1'b1, (k == 0) ? d + 2 : 2, "rd_gap");
            got = '0; nb = 0; guard = 0; held = 1'b0;
            while (nb < 8 && guard < 100) begin
                guard++;
                check("rd_valid", bus.s_slave_valid, 1);
                bit_now = bus.s_tx_data;
                if (stall_pct < 0 && nb == 4 && !held) begin
                    held = 1'b1;
                    bus.s_master_ready = 1'b0;
                    repeat (3) begin
                        @(negedge clk);
                        check("rd_hold_bit", bus.s_tx_data, bit_now);
                    end
                end else if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                    bus.s_master_ready = 1'b0;
                    @(negedge clk);
                    check("rd_hold_bit", bus.s_tx_data, bit_now);
                end else begin
                    bus.s_master_ready = 1'b1;
                    got[nb] = bit_now;
                    nb++;
                    @(negedge clk);
                end
            end
            bus.s_master_ready = 1'b0;
            check("rd_byte", got, model[(int'(a) + k) % 4096]);
        end
        check("rd_end_rdy", bus.s_slave_ready, 1);
        check("rd_end_valid", bus.s_slave_valid, 0);
        idle_bus();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [11:0] ra;
        logic [11:0] rb;
        idle_bus();
        bus.s_slave_delay = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", bus.s_slave_ready, 1);
        check("reset_valid", bus.s_slave_valid, 0);
        check("reset_tx", bus.s_tx_data, 0);
        check("reset_split", bus.s_split_en, 0);
        rst = 1'b1;
        @(negedge clk);

        wbuf[0] = 8'hA5;
        write_burst(12'h123, 12'd1, 0, 0, -1, -1);
        read_burst(12'h123, 12'd1, 0, 0);

        wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
        write_burst(12'hFFE, 12'd3, 0, 0, -1, -1);
        read_burst(12'hFFE, 12'd3, 0, 0);
        read_burst(12'h000, 12'd1, 0, 0);

        wbuf[0] = 8'hC3;
        write_burst(12'h456, 12'd1, 5, 0, -1, -1);
        read_burst(12'h456, 12'd1, 5, 0);

        wbuf[0] = 8'h5A;
        write_burst(12'h2B7, 12'd1, 0, -1, -1, -1);
        read_burst(12'h2B7, 12'd1, 0, -1);

        wbuf[0] = 8'h01; wbuf[1] = 8'h02; wbuf[2] = 8'h03;
        write_burst(12'h700, 12'd3, 0, 0, -1, -1);
        wbuf[0] = 8'hA1; wbuf[1] = 8'hB2; wbuf[2] = 8'hC3;
        write_burst(12'h700, 12'd3, 0, 0, 1, 4);
        read_burst(12'h700, 12'd3, 0, 0);

        bus.s_read_en  = 1'b1;
        bus.s_write_en = 1'b1;
        for (int i = 0; i < 14; i++) begin
            bus.s_master_valid = 1'b1;
            bus.s_rx_address   = 1'($urandom_range(1));
            bus.s_rx_burst     = 1'($urandom_range(1));
            bus.s_rx_data      = 1'($urandom_range(1));
            @(negedge clk);
            check("both_en_rdy", bus.s_slave_ready, 1);
        end
        check("both_en_state", 32'(dut.r_state), 32'(ST_IDLE));
        idle_bus();
        @(negedge clk);
        read_burst(12'h123, 12'd1, 0, 0);

        for (int t = 0; t < 24; t++) begin
            ra = 12'($urandom_range(4095));
            rb = 12'($urandom_range(0, 4));
            for (int k = 0; k < 16; k++) wbuf[k] = 8'($urandom_range(255));
            write_burst(ra, rb, int'($urandom_range(0, 3)), 25, -1, -1);
            read_burst(ra, rb, int'($urandom_range(0, 3)), 25);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
